// File: rtl/freq_div_prog.sv
//-----------------------------------------------------------------------------
// freq_div_prog
//
// Programmable clock divider. Divides clk by a runtime divisor P in
// 1..2^WIDTH-1 (even or odd). New divisors are captured into a shadow
// register and only become active at a period boundary, so the output never
// produces a runt pulse. P = 1 bypasses the counter (out = clk & enable);
// P = 0 parks the block idle with out low.
//
// Optional feature: define FREQ_DIV_ODD_DUTY50_EN to add a falling-edge
// stage that trims the high phase of odd divisors (P >= 3) to exactly P/2
// clocks, giving a 50% duty cycle. Without it, odd P is high (P+1)/2 clocks.
//
// Parameters:
//   WIDTH     - width of the divisor and period counter
//   RESET_DIV - divisor held in shadow and active registers after reset
//
// Ports:
//   clk     in   reference clock
//   reset_n in   asynchronous active-low reset
//   enable  in   count enable; when low all period state freezes
//   load    in   one-cycle strobe capturing p_in into the shadow divisor
//   p_in    in   new divisor value [WIDTH]
//   out     out  divided clock
//   tick    out  registered one-cycle pulse on the first cycle of a period
//   active  out  high when the active divisor is non-zero
//-----------------------------------------------------------------------------
module freq_div_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    output logic             out,
    output logic             tick,
    output logic             active
);

    localparam logic [WIDTH-1:0] RESET_P = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] p_shadow_q, p_shadow_d;
    logic [WIDTH-1:0] p_active_q, p_active_d;
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic             out_q,      out_d;
    logic             tick_q,     tick_d;
    // Set by reset so the first enabled edge opens a fresh period with a tick,
    // even though cnt starts at 0 rather than at p_active-1.
    logic             start_q,    start_d;

    logic [WIDTH-1:0] p_nxt;
    logic             boundary;
    logic [WIDTH:0]   half;     // ceil(p_active/2), one bit wider: no overflow at all-ones
    logic [WIDTH:0]   cnt_inc;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        p_shadow_d = load ? p_in : p_shadow_q;
        p_active_d = p_active_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        tick_d     = 1'b0;
        start_d    = start_q;

        // A load coincident with a boundary takes effect at that boundary.
        p_nxt   = load ? p_in : p_shadow_q;
        half    = ({1'b0, p_active_q} + (WIDTH+1)'(1)) >> 1;
        cnt_inc = {1'b0, cnt_q} + (WIDTH+1)'(1);

        boundary = enable && (start_q || (p_active_q == '0) ||
                              (cnt_q == p_active_q - WIDTH'(1)));

        if (boundary) begin
            start_d    = 1'b0;
            p_active_d = p_nxt;
            cnt_d      = '0;
            out_d      = (p_nxt != '0);
            tick_d     = (p_nxt != '0);
        end else if (enable) begin
            cnt_d = cnt_inc[WIDTH-1:0];
            out_d = (cnt_inc < half);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_shadow_q <= RESET_P;
            p_active_q <= RESET_P;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
            start_q    <= 1'b1;
        end else begin
            p_shadow_q <= p_shadow_d;
            p_active_q <= p_active_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
            start_q    <= start_d;
        end
    end

`ifdef FREQ_DIV_ODD_DUTY50_EN
    // Half-cycle delayed copy of out_q; ANDing trims half a clock off the
    // high phase of odd divisors.
    logic out_neg_q, out_neg_d;
    logic odd_div;

    assign out_neg_d = out_q;
    assign odd_div   = p_active_q[0] && (p_active_q != WIDTH'(1));

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_neg_q <= 1'b0;
        end else begin
            out_neg_q <= out_neg_d;
        end
    end
`endif

    always_comb begin
        if (p_active_q == '0) begin
            out = 1'b0;
        end else if (p_active_q == WIDTH'(1)) begin
            // Bypass: the counter cannot produce a full-rate clock.
            out = clk & enable;
`ifdef FREQ_DIV_ODD_DUTY50_EN
        end else if (odd_div) begin
            out = out_q & out_neg_q;
`endif
        end else begin
            out = out_q;
        end
    end

    assign tick   = tick_q;
    assign active = (p_active_q != '0);

endmodule

// File: tb/tb_freq_div_prog.sv
//-----------------------------------------------------------------------------
// tb_freq_div_prog
//
// Scoreboard bench for freq_div_prog. The stimulus process drives inputs on
// the falling edge, advances a period-level reference model (divisor, position
// within the period, shadow divisor) and queues the expected outputs. The
// monitor samples the DUT 1 ns after each rising edge and compares against the
// queue head. Directed scenarios are followed by randomized traffic with
// occasional mid-period resets.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_div_prog;

    localparam int WIDTH     = 8;
    localparam int RESET_DIV = 0;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] p_in;
    logic             out;
    logic             tick;
    logic             active;

    always #5 clk = ~clk;

    freq_div_prog #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (load),
        .p_in    (p_in),
        .out     (out),
        .tick    (tick),
        .active  (active)
    );

    typedef struct {
        logic o;
        logic t;
        logic a;
        int   id;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int n_step = 0;

    // Reference model: divisor in use, cycles elapsed in the current period,
    // pending divisor, divided level now and one half-cycle earlier.
    int m_shadow;
    int m_p;
    int m_pos;
    bit m_level;
    bit m_level_prev;
    bit m_fresh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_shadow     = RESET_DIV;
        m_p          = RESET_DIV;
        m_pos        = 0;
        m_level      = 1'b0;
        m_level_prev = 1'b0;
        m_fresh      = 1'b1;
    endfunction

    // One rising edge of the reference model.
    task automatic step(input bit en, input bit ld, input int p);
        int   nxt;
        bit   tk;
        exp_t e;
        @(negedge clk);
        enable = en;
        load   = ld;
        p_in   = WIDTH'(p);
        n_step++;

        nxt          = ld ? p : m_shadow;
        m_level_prev = m_level;
        tk           = 1'b0;
        if (en && (m_fresh || m_p == 0 || m_pos == m_p - 1)) begin
            m_p     = nxt;
            m_pos   = 0;
            m_fresh = 1'b0;
            m_level = (nxt != 0);
            tk      = (nxt != 0);
        end else if (en) begin
            m_pos   = m_pos + 1;
            // High for the first ceil(P/2) cycles of the period.
            m_level = (m_pos < (m_p + 1) / 2);
        end
        if (ld) m_shadow = p;

        if (m_p == 0)      e.o = 1'b0;
        else if (m_p == 1) e.o = en;   // sampled while clk is high
`ifdef FREQ_DIV_ODD_DUTY50_EN
        else if (m_p % 2 == 1) e.o = m_level & m_level_prev;
`endif
        else               e.o = m_level;
        e.t  = tk;
        e.a  = (m_p != 0);
        e.id = n_step;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    // Reset asserted between edges: outputs must drop without a clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        enable  = 1'b0;
        load    = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_out",    32'(out),    32'(0));
        check("rst_tick",   32'(tick),   32'(0));
        check("rst_active", 32'(active), 32'(RESET_DIV != 0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation after its rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("out@%0d", e.id),    32'(out),    32'(e.o));
                check($sformatf("tick@%0d", e.id),   32'(tick),   32'(e.t));
                check($sformatf("active@%0d", e.id), 32'(active), 32'(e.a));
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int guard;
        reset_n = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        p_in    = '0;
        model_reset();
        #12;
        check("init_out",    32'(out),    32'(0));
        check("init_tick",   32'(tick),   32'(0));
        check("init_active", 32'(active), 32'(RESET_DIV != 0));
        @(negedge clk);
        reset_n = 1'b1;

        // Divide by 4, then by 5.
        step(1'b1, 1'b1, 4);
        run(12);
        step(1'b1, 1'b1, 5);
        run(15);

        // Running at 6, load 3 when the count reaches 2.
        step(1'b1, 1'b1, 6);
        guard = 0;
        while (!(m_p == 6 && m_pos == 2) && guard < 20) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        check("reach_p6_cnt2", 32'(guard < 20), 32'(1));
        step(1'b1, 1'b1, 3);
        run(12);

        // Go idle.
        step(1'b1, 1'b1, 0);
        run(12);

        // Bypass, then drop enable.
        step(1'b1, 1'b1, 1);
        run(5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        run(2);

        // Divide by 8 with a 3-cycle stall at count 3, then reset mid-period.
        step(1'b1, 1'b1, 8);
        guard = 0;
        while (!(m_p == 8 && m_pos == 3) && guard < 20) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        check("reach_p8_cnt3", 32'(guard < 20), 32'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        run(14);
        reset_mid();

        // Load while disabled, then shadow-only back-to-back loads.
        step(1'b0, 1'b1, 7);
        step(1'b0, 1'b1, 2);
        run(8);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            bit en;
            bit ld;
            int r;
            int p;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 15) == 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      p = 0;
            else if (r == 1) p = 1;
            else if (r == 2) p = (1 << WIDTH) - 1;
            else             p = int'($urandom_range(2, 12));
            step(en, ld, p);
            if ($urandom_range(0, 299) == 0) reset_mid();
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
